// File: rtl/cache_pkg.sv
// Shared definitions for the N-way set-associative cache: FSM encoding,
// width helpers and line/word slicing.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND
    } state_t;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 256;
    localparam int DEF_LINE_BYTES = 64;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int offset_bits(input int line_bytes);
        return clog2(line_bytes);
    endfunction

    function automatic int index_bits(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int line_bytes);
        return addr_w - index_bits(sets) - offset_bits(line_bytes);
    endfunction

    // Bit position inside a line of the CPU word holding byte_off.
    function automatic int word_lo(input int byte_off, input int data_w);
        return (byte_off / (data_w / 8)) * data_w;
    endfunction

endpackage

// File: rtl/nway_sa_cache_if.sv
// Core-side request/response and memory-side line transfer signals of the cache.
interface nway_sa_cache_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 64
);
    logic                    cpu_req_valid;
    logic                    cpu_req_ready;
    logic                    cpu_req_we;
    logic [ADDR_W-1:0]       cpu_req_addr;
    logic [DATA_W-1:0]       cpu_req_wdata;
    logic [DATA_W/8-1:0]     cpu_req_wstrb;
    logic                    cpu_rsp_valid;
    logic [DATA_W-1:0]       cpu_rsp_rdata;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_we;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic [LINE_BYTES*8-1:0] mem_req_wline;
    logic                    mem_rsp_valid;
    logic [LINE_BYTES*8-1:0] mem_rsp_rline;

    // slave is the cache itself; master is the core plus memory around it.
    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rline,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wline
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rline,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wline
    );
endinterface

// File: rtl/cache_lru_ctrl.sv
// True-LRU age update and victim selection for one set (age 0 = most recent).
module cache_lru_ctrl
    import cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = clog2(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] age,
    input  logic [WAY_W-1:0]           hit_way,
    input  logic [WAYS-1:0]            valid,
    output logic [WAYS-1:0][WAY_W-1:0] age_next,
    output logic [WAY_W-1:0]           victim
);
    logic found_free;

    always_comb begin
        age_next = age;
        for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == hit_way)
                age_next[w] = '0;
            else if (age[w] < age[hit_way])
                age_next[w] = age[w] + WAY_W'(1);
        end
    end

    always_comb begin
        victim     = '0;
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_free && !valid[w]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end
endmodule

// File: rtl/nway_sa_cache.sv
// Blocking N-way set-associative write-back/write-allocate cache with true LRU.
//   state       | meaning
//   IDLE        | ready for a CPU request
//   LOOKUP      | tag compare; hit completes, miss picks a victim
//   WRITEBACK   | dirty victim line offered to memory
//   REFILL_REQ  | line read request offered to memory
//   REFILL_WAIT | waiting for refill data; install then replay lookup
//   RESPOND     | one-cycle response to the CPU
module nway_sa_cache
    import cache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    nway_sa_cache_if.slave   bus,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
);
    localparam int OFFSET_BITS = offset_bits(LINE_BYTES);
    localparam int INDEX_BITS  = index_bits(SETS);
    localparam int TAG_BITS    = tag_bits(ADDR_W, SETS, LINE_BYTES);
    localparam int LINE_W      = LINE_BYTES * 8;
    localparam int LINE_IDX_W  = clog2(LINE_W);
    localparam int STRB_W      = DATA_W / 8;
    localparam int WAY_W       = clog2(WAYS);

    state_t state_q, state_d;

    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [STRB_W-1:0]   req_wstrb_q;
    logic                replay_q;
    logic [WAY_W-1:0]    victim_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [31:0]         hits_q, misses_q;

    logic [TAG_BITS-1:0]           tag_q   [WAYS][SETS];
    logic [LINE_W-1:0]             data_q  [WAYS][SETS];
    logic [SETS-1:0]               valid_q [WAYS];
    logic [SETS-1:0]               dirty_q [WAYS];
    logic [WAYS-1:0][WAY_W-1:0]    age_q   [SETS];

    logic [TAG_BITS-1:0]        req_tag;
    logic [INDEX_BITS-1:0]      req_index;
    logic [OFFSET_BITS-1:0]     req_off;
    logic [LINE_IDX_W-1:0]      word_pos;
    logic [WAYS-1:0]            set_valid, hit_vec;
    logic                       hit, victim_dirty;
    logic [WAY_W-1:0]           hit_way, victim;
    logic [WAYS-1:0][WAY_W-1:0] set_age, age_next;
    logic [LINE_W-1:0]          hit_line, wr_line;
    logic [DATA_W-1:0]          old_word, merged_word;

    assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_BITS];
    assign req_index = req_addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_off   = req_addr_q[OFFSET_BITS-1:0];
    assign word_pos  = LINE_IDX_W'(word_lo(int'(req_off), DATA_W));
    assign set_age   = age_q[req_index];

    always_comb begin
        hit_vec   = '0;
        set_valid = '0;
        hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][req_index];
            hit_vec[w]   = set_valid[w] && (tag_q[w][req_index] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit          = |hit_vec;
    assign victim_dirty = valid_q[victim][req_index] && dirty_q[victim][req_index];

    cache_lru_ctrl #(.WAYS(WAYS)) u_lru (
        .age      (set_age),
        .hit_way  (hit_way),
        .valid    (set_valid),
        .age_next (age_next),
        .victim   (victim)
    );

    // Reads see the word after any strobed write, so one merge serves both.
    always_comb begin
        hit_line = data_q[hit_way][req_index];
        old_word = hit_line[word_pos +: DATA_W];
        for (int b = 0; b < STRB_W; b++)
            merged_word[8*b +: 8] = (req_we_q && req_wstrb_q[b]) ? req_wdata_q[8*b +: 8]
                                                                  : old_word[8*b +: 8];
        wr_line = hit_line;
        wr_line[word_pos +: DATA_W] = merged_word;
    end

    always_comb begin
        state_d           = state_q;
        bus.cpu_req_ready = 1'b0;
        bus.cpu_rsp_valid = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit)               state_d = RESPOND;
                else if (victim_dirty) state_d = WRITEBACK;
                else                   state_d = REFILL_REQ;
            end
            WRITEBACK: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                if (bus.mem_req_ready) state_d = REFILL_REQ;
            end
            REFILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                if (bus.mem_rsp_valid) state_d = LOOKUP;
            end
            RESPOND: begin
                bus.cpu_rsp_valid = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req_addr  = (state_q == WRITEBACK)
                             ? {tag_q[victim_q][req_index], req_index, {OFFSET_BITS{1'b0}}}
                             : {req_tag, req_index, {OFFSET_BITS{1'b0}}};
    assign bus.mem_req_wline = (state_q == WRITEBACK) ? data_q[victim_q][req_index] : '0;
    assign bus.cpu_rsp_rdata = rsp_rdata_q;
    assign stat_hits         = hits_q;
    assign stat_misses       = misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            replay_q    <= 1'b0;
            victim_q    <= '0;
            rsp_rdata_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        req_we_q    <= bus.cpu_req_we;
                        req_addr_q  <= bus.cpu_req_addr;
                        req_wdata_q <= bus.cpu_req_wdata;
                        req_wstrb_q <= bus.cpu_req_wstrb;
                    end
                end
                LOOKUP: begin
                    replay_q <= 1'b0;
                    if (hit) begin
                        age_q[req_index] <= age_next;
                        rsp_rdata_q      <= merged_word;
                        if (req_we_q) dirty_q[hit_way][req_index] <= 1'b1;
                        if (!replay_q && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
                    end else begin
                        victim_q <= victim;
                        if (!replay_q && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        valid_q[victim_q][req_index] <= 1'b1;
                        dirty_q[victim_q][req_index] <= 1'b0;
                        replay_q                     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == LOOKUP && hit && req_we_q)
                data_q[hit_way][req_index] <= wr_line;
            if (state_q == REFILL_WAIT && bus.mem_rsp_valid) begin
                data_q[victim_q][req_index] <= bus.mem_rsp_rline;
                tag_q[victim_q][req_index]  <= req_tag;
            end
        end
    end
endmodule

// File: tb/tb_nway_sa_cache.sv
// Directed bench for nway_sa_cache with hand-computed expectations.
module tb_nway_sa_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stat_hits, stat_misses;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_req_cycles = 0;

    nway_sa_cache_if #(.ADDR_W(32), .DATA_W(32), .LINE_BYTES(64)) bus ();

    nway_sa_cache #(.WAYS(4), .SETS(256), .LINE_BYTES(64), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.mem_req_valid === 1'b1) mem_req_cycles <= mem_req_cycles + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] w0, input logic [31:0] w1);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h0F0F_0000 + 32'(i);
        l[31:0]  = w0;
        l[63:32] = w1;
        return l;
    endfunction

    task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_we    = we;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wdata;
        bus.cpu_req_wstrb = wstrb;
        while (bus.cpu_req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready_seen", (n < 100), 1'b1);
        acc_cyc = cyc;
        @(posedge clk);
        #1 bus.cpu_req_valid = 1'b0;
    endtask

    task automatic cpu_wait_rsp(output logic [31:0] rdata, output int rsp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cpu_rsp_valid !== 1'b1 && n < 200);
        check("rsp_seen", bus.cpu_rsp_valid, 1'b1);
        rdata   = bus.cpu_rsp_rdata;
        rsp_cyc = cyc;
    endtask

    task automatic mem_wait_req(input string tag);
        int n;
        n = 0;
        while (bus.mem_req_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.mem_req_valid, 1'b1);
    endtask

    task automatic mem_accept();
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_req_ready = 1'b0;
    endtask

    task automatic mem_reply(input logic [511:0] line);
        @(negedge clk);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rline = line;
        @(posedge clk);
        #1 bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic read_miss(input string tag, input logic [31:0] addr,
                             input logic [511:0] line, input logic [31:0] exp_rdata);
        int          acc, rc;
        logic [31:0] rd;
        cpu_issue(1'b0, addr, 32'h0, 4'h0, acc);
        mem_wait_req({tag, "_memreq"});
        check({tag, "_mem_we"}, bus.mem_req_we, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_req_addr, addr & ~32'h3F);
        mem_accept();
        mem_reply(line);
        cpu_wait_rsp(rd, rc);
        check({tag, "_rdata"}, rd, exp_rdata);
    endtask

    task automatic hit_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] exp_rdata);
        int          acc, rc, m0;
        logic [31:0] rd;
        cpu_issue(we, addr, wdata, wstrb, acc);
        m0 = mem_req_cycles;
        cpu_wait_rsp(rd, rc);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_latency"}, 64'(rc - acc), 64'd2);
        #1 check({tag, "_no_memreq"}, 64'(mem_req_cycles - m0), 64'd0);
        @(negedge clk);
        check({tag, "_ready_T3"}, bus.cpu_req_ready, 1'b1);
        check({tag, "_rdata_hold"}, bus.cpu_rsp_rdata, exp_rdata);
    endtask

    initial begin
        int          acc, rc;
        logic [31:0] rd;

        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_we    = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.cpu_req_wdata = '0;
        bus.cpu_req_wstrb = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rline = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus.cpu_req_ready, 1'b1);
        check("rst_mem_valid", bus.mem_req_valid, 1'b0);
        check("rst_rsp_valid", bus.cpu_rsp_valid, 1'b0);
        check("rst_hits", stat_hits, 32'd0);
        check("rst_misses", stat_misses, 32'd0);

        read_miss("rd1000", 32'h0000_1000, make_line(32'hDEAD_BEEF, 32'hCAFE_0001), 32'hDEAD_BEEF);
        check("rd1000_misses", stat_misses, 32'd1);
        check("rd1000_hits", stat_hits, 32'd0);

        hit_access("rd1004", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hCAFE_0001);
        check("rd1004_hits", stat_hits, 32'd1);

        hit_access("wr1000", 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 32'hDEAD_5678);
        hit_access("rd1000b", 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_5678);
        check("hits_after_wr", stat_hits, 32'd3);

        read_miss("rd5000", 32'h0000_5000, make_line(32'h5555_0000, 32'h5555_0001), 32'h5555_0000);
        read_miss("rd9000", 32'h0000_9000, make_line(32'h9999_0000, 32'h9999_0001), 32'h9999_0000);
        read_miss("rdD000", 32'h0000_D000, make_line(32'hDDDD_0000, 32'hDDDD_0001), 32'hDDDD_0000);
        check("misses_4", stat_misses, 32'd4);

        // way 0 (0x1000) is both dirty and oldest, so it is evicted first
        cpu_issue(1'b0, 32'h0001_1000, 32'h0, 4'h0, acc);
        mem_wait_req("wb_memreq");
        for (int i = 0; i < 10; i++) begin
            check("wb_hold_valid", bus.mem_req_valid, 1'b1);
            check("wb_hold_we", bus.mem_req_we, 1'b1);
            check("wb_hold_addr", bus.mem_req_addr, 32'h0000_1000);
            check("wb_hold_word0", bus.mem_req_wline[31:0], 32'hDEAD_5678);
            @(negedge clk);
        end
        check("wb_word1", bus.mem_req_wline[63:32], 32'hCAFE_0001);
        mem_accept();
        mem_wait_req("rf11000_memreq");
        check("rf11000_we", bus.mem_req_we, 1'b0);
        check("rf11000_addr", bus.mem_req_addr, 32'h0001_1000);
        mem_accept();
        mem_reply(make_line(32'h1111_0000, 32'h1111_0001));
        cpu_wait_rsp(rd, rc);
        check("rd11000_rdata", rd, 32'h1111_0000);
        check("misses_5", stat_misses, 32'd5);

        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rline = make_line(32'hBADB_AD00, 32'hBADB_AD01);
        @(posedge clk);
        #1 bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("stray_ready", bus.cpu_req_ready, 1'b1);
        check("stray_memreq", bus.mem_req_valid, 1'b0);
        hit_access("rd11000b", 1'b0, 32'h0001_1000, 32'h0, 4'h0, 32'h1111_0000);
        hit_access("rd5000b", 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h5555_0000);
        check("hits_5", stat_hits, 32'd5);
        check("misses_still_5", stat_misses, 32'd5);

        // 0x21000 evicts clean way 2 (0x9000): straight to refill, no writeback
        cpu_issue(1'b0, 32'h0002_1000, 32'h0, 4'h0, acc);
        mem_wait_req("rf21000_memreq");
        check("rf21000_we", bus.mem_req_we, 1'b0);
        check("rf21000_addr", bus.mem_req_addr, 32'h0002_1000);
        mem_accept();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", bus.cpu_req_ready, 1'b1);
        check("midrst_mem_valid", bus.mem_req_valid, 1'b0);
        check("midrst_hits", stat_hits, 32'd0);
        check("midrst_misses", stat_misses, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rline = make_line(32'h2222_0000, 32'h2222_0001);
        @(posedge clk);
        #1 bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_ready", bus.cpu_req_ready, 1'b1);
        check("late_rsp_rspvalid", bus.cpu_rsp_valid, 1'b0);

        read_miss("post_rst_rd1000", 32'h0000_1000, make_line(32'h0BAD_F00D, 32'h0BAD_F00E), 32'h0BAD_F00D);
        check("post_rst_misses", stat_misses, 32'd1);
        check("post_rst_hits", stat_hits, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
